// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample arbiter.
package dac_pkg;

    localparam int DAC_DATA_W = 16;
    localparam int UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        // Walk farthest-first so the nearest hit after last_grant wins.
        for (int k = N_CH; k >= 1; k--) begin
            idx = IDX_W'((int'(last_grant) + k) % N_CH);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/dac_sample_arbiter.sv
// Per-channel sample holding buffers feeding one DAC driver stream via round-robin.
// m_axis_valid/m_axis_data go to the driver's input stream; its ready is dac_ready.
module dac_sample_arbiter
    import dac_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = DAC_DATA_W
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_CH-1:0]              chan_mask,
    input  logic [N_CH-1:0]              s_axis_valid,
    output logic [N_CH-1:0]              s_axis_ready,
    input  logic [N_CH-1:0][DATA_W-1:0]  s_axis_data,
    output logic                         m_axis_valid,
    output logic [DATA_W-1:0]            m_axis_data,
    input  logic                         dac_ready,
    output logic [$clog2(N_CH)-1:0]      grant_id,
    output logic [UNDERRUN_W-1:0]        underrun_cnt
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CH - 1);

    arb_state_e                  r_state;
    logic [N_CH-1:0]             r_full;
    logic [N_CH-1:0][DATA_W-1:0] r_buf;
    logic                        r_valid;
    logic [DATA_W-1:0]           r_data;
    logic [IDX_W-1:0]            r_gid;
    logic [IDX_W-1:0]            r_last;
    logic [UNDERRUN_W-1:0]       r_underrun;

    logic [N_CH-1:0]             w_ready;
    logic [N_CH-1:0]             w_take;
    logic [N_CH-1:0]             w_req;
    logic                        w_gnt_vld;
    logic [IDX_W-1:0]            w_gnt_idx;
    logic                        w_underrun;

    // No bypass: a buffer being drained this cycle still reports not-ready.
    assign w_ready    = {N_CH{en & ~rst}} & chan_mask & ~r_full;
    assign w_take     = s_axis_valid & w_ready;
    assign w_req      = r_full & chan_mask;
    assign w_underrun = dac_ready & ~r_valid & (r_state != IDLE);

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (w_req),
        .last_grant  (r_last),
        .grant_valid (w_gnt_vld),
        .grant_idx   (w_gnt_idx)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_full     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_gid      <= '0;
            r_last     <= LAST_RST;
            r_underrun <= '0;
        end else if (!en) begin
            // Disable flushes buffers and the presented sample; counters persist.
            r_state <= IDLE;
            r_full  <= '0;
            r_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_take[i]) begin
                    r_full[i] <= 1'b1;
                    r_buf[i]  <= s_axis_data[i];
                end
            end
            if (w_underrun && (r_underrun != '1))
                r_underrun <= r_underrun + 1'b1;
            case (r_state)
                IDLE: r_state <= ARB;
                ARB: begin
                    if (w_gnt_vld) begin
                        r_full[w_gnt_idx] <= 1'b0;
                        r_data            <= r_buf[w_gnt_idx];
                        r_gid             <= w_gnt_idx;
                        r_last            <= w_gnt_idx;
                        r_valid           <= 1'b1;
                        r_state           <= HOLD;
                    end
                end
                HOLD: begin
                    if (dac_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ARB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_axis_ready = w_ready;
    assign m_axis_valid = r_valid;
    assign m_axis_data  = r_data;
    assign grant_id     = r_gid;
    assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Randomized and directed bench for dac_sample_arbiter against a behavioural model.
module tb_dac_sample_arbiter;

    localparam int N = 4;

    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [N-1:0]      chan_mask = '0;
    logic [N-1:0]      s_axis_valid = '0;
    logic [N-1:0]      s_axis_ready;
    logic [N-1:0][15:0] s_axis_data = '0;
    logic              m_axis_valid;
    logic [15:0]       m_axis_data;
    logic              dac_ready = 1'b0;
    logic [1:0]        grant_id;
    logic [15:0]       underrun_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 mclk = ~mclk;

    dac_sample_arbiter #(.N_CH(N), .DATA_W(16)) dut (
        .mclk         (mclk),
        .rst          (rst),
        .en           (en),
        .chan_mask    (chan_mask),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_data  (s_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .dac_ready    (dac_ready),
        .grant_id     (grant_id),
        .underrun_cnt (underrun_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the DUT must hold after the next clock edge.
    bit          m_act = 0;
    bit          m_pres = 0;
    logic [15:0] m_data = '0;
    int          m_gid = 0;
    int          m_last = N - 1;
    int          m_uc = 0;
    bit [N-1:0]  m_full = '0;
    logic [15:0] m_buf [N];

    function automatic int rr_pick(input bit [N-1:0] elig, input int last);
        for (int k = 1; k <= N; k++)
            if (elig[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit [N-1:0] elig;
        bit [N-1:0] take;
        int pick;
        if (rst) begin
            m_act = 0; m_pres = 0; m_data = '0; m_gid = 0;
            m_last = N - 1; m_uc = 0; m_full = '0;
        end else if (!en) begin
            m_act = 0; m_pres = 0; m_full = '0;
        end else begin
            elig = m_full & chan_mask;
            take = s_axis_valid & chan_mask & ~m_full;
            if (m_act && !m_pres && dac_ready && m_uc < 16'hFFFF) m_uc++;
            if (!m_act) m_act = 1;
            else if (!m_pres) begin
                pick = rr_pick(elig, m_last);
                if (pick >= 0) begin
                    m_pres = 1; m_data = m_buf[pick]; m_gid = pick;
                    m_last = pick; m_full[pick] = 0;
                end
            end else if (dac_ready) m_pres = 0;
            for (int i = 0; i < N; i++)
                if (take[i]) begin m_full[i] = 1; m_buf[i] = s_axis_data[i]; end
        end
    endtask

    always @(negedge mclk) begin
        if (chk_en) begin
            check("m_valid", m_axis_valid, m_pres);
            if (m_pres) begin
                check("m_data", m_axis_data, m_data);
                check("grant_id", grant_id, m_gid);
            end
            check("underrun", underrun_cnt, m_uc);
            check("s_ready", s_axis_ready, (en && !rst) ? (chan_mask & ~m_full) : '0);
        end
        model_step();
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse_ready();
        dac_ready = 1'b1;
        tick();
        dac_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m_axis_valid && n < 20) begin tick(); n++; end
        check(name, m_axis_valid, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_rdy;
        // Reset values
        tick(); tick();
        chk_en = 1'b1;
        check("rst_valid", m_axis_valid, 0);
        check("rst_data", m_axis_data, 0);
        check("rst_gid", grant_id, 0);
        check("rst_uc", underrun_cnt, 0);
        check("rst_ready", s_axis_ready, 0);
        rst = 1'b0; en = 1'b1; chan_mask = 4'b0001;
        tick();

        // Three underrun pulses with nothing buffered
        for (int p = 0; p < 3; p++) begin pulse_ready(); tick(); end
        check("uc_three", underrun_cnt, 3);

        // Single channel latency and hold
        s_axis_valid = 4'b0001; s_axis_data[0] = 16'h1234;
        tick();
        s_axis_valid = '0;
        check("lat_t1_valid", m_axis_valid, 0);
        tick();
        check("lat_t2_valid", m_axis_valid, 1);
        check("lat_t2_data", m_axis_data, 16'h1234);
        check("lat_t2_gid", grant_id, 0);
        repeat (5) begin tick(); check("hold_data", m_axis_data, 16'h1234); end
        pulse_ready();
        check("release_valid", m_axis_valid, 0);

        // Reset in the middle of HOLD
        chan_mask = 4'b1111;
        s_axis_valid = 4'b0010; s_axis_data[1] = 16'hD111;
        tick(); s_axis_valid = '0; tick();
        check("pre_rst_gid", grant_id, 1);
        rst = 1'b1; s_axis_valid = 4'b1111;
        #1 check("ready_in_rst", s_axis_ready, 0);
        tick();
        check("midrst_valid", m_axis_valid, 0);
        check("midrst_data", m_axis_data, 0);
        check("midrst_gid", grant_id, 0);
        check("midrst_uc", underrun_cnt, 0);
        rst = 1'b0;

        // Fairness with every channel kept full
        for (int i = 0; i < N; i++) s_axis_data[i] = 16'hA000 + 16'(i);
        for (int g = 0; g < 8; g++) begin
            wait_valid("fair_valid");
            check("fair_gid", grant_id, g % N);
            check("fair_data", m_axis_data, 16'hA000 + 16'(g % N));
            check("model_pin_gid", m_gid, g % N);
            if (g < 7) begin repeat (100) tick(); pulse_ready(); end
        end

        // Disable during HOLD
        en = 1'b0; s_axis_valid = '0;
        #1 check("dis_ready", s_axis_ready, 0);
        tick();
        check("dis_valid", m_axis_valid, 0);
        check("dis_uc", underrun_cnt, 0);
        en = 1'b1;
        repeat (6) tick();
        check("dis_flushed", m_axis_valid, 0);

        // Masking keeps a buffered sample but blocks it until re-enabled
        s_axis_valid = 4'b0001; s_axis_data[0] = 16'hB000;
        tick(); s_axis_valid = '0; tick();
        check("mask_g0", grant_id, 0);
        s_axis_valid = 4'b1110;
        s_axis_data[1] = 16'hB111; s_axis_data[2] = 16'hC222; s_axis_data[3] = 16'hB333;
        tick(); s_axis_valid = '0;
        chan_mask = 4'b1011;
        #1 check("mask_ready", s_axis_ready, 4'b0001);
        pulse_ready(); tick();
        check("mask_g1", grant_id, 1);
        check("mask_d1", m_axis_data, 16'hB111);
        pulse_ready(); tick();
        check("mask_g3", grant_id, 3);
        pulse_ready();
        repeat (10) begin tick(); check("mask_blocked", m_axis_valid, 0); end
        check("mask_rdy2", s_axis_ready[2], 0);
        chan_mask = 4'b1111;
        tick();
        check("unmask_valid", m_axis_valid, 1);
        check("unmask_gid", grant_id, 2);
        check("unmask_data", m_axis_data, 16'hC222);
        pulse_ready();

        // Random traffic
        prev_rdy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 49) != 0);
            chan_mask = 4'($urandom) | 4'($urandom);
            s_axis_valid = 4'($urandom);
            for (int i = 0; i < N; i++) s_axis_data[i] = 16'($urandom);
            dac_ready = !prev_rdy && ($urandom_range(0, 3) == 0);
            prev_rdy = dac_ready;
            tick();
        end

        // Underrun saturation; the IDLE cycle must not count
        rst = 1'b1; en = 1'b0; dac_ready = 1'b0; s_axis_valid = '0; chan_mask = '0;
        tick();
        rst = 1'b0; en = 1'b1; dac_ready = 1'b1;
        tick();
        check("idle_ignored", underrun_cnt, 0);
        tick();
        check("uc_first", underrun_cnt, 1);
        repeat (65540) tick();
        check("uc_sat", underrun_cnt, 16'hFFFF);
        dac_ready = 1'b0; tick();
        pulse_ready();
        check("uc_sat_hold", underrun_cnt, 16'hFFFF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_sample_arbiter.md
DAC_SAMPLE_ARBITER -- requirements
Module: dac_sample_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of sample requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-003 SHALL have port mclk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port en, input, 1, global enable.
REQ-006 SHALL have port chan_mask, input, N_CH, per-channel eligibility (1 = enabled).
REQ-007 SHALL have port s_axis_valid, input, N_CH, per-requester valid.
REQ-008 SHALL have port s_axis_ready, output, N_CH, per-requester ready.
REQ-009 SHALL have port s_axis_data, input, N_CH x DATA_W, per-requester sample.
REQ-010 SHALL have port m_axis_valid, output, 1, sample presented to the DAC driver.
REQ-011 SHALL have port m_axis_data, output, DATA_W, presented sample.
REQ-012 SHALL have port dac_ready, input, 1, single-cycle load pulse from the DAC driver (IDLE->LOAD).
REQ-013 SHALL have port grant_id, output, clog2(N_CH), channel of the presented sample.
REQ-014 SHALL have port underrun_cnt, output, 16, dac_ready pulses with m_axis_valid low.

Function
REQ-015 SHALL hold one sample per channel in a holding register with a full flag.
REQ-016 SHALL drive s_axis_ready[i] = en & chan_mask[i] & ~full[i], combinationally, with no bypass; a full buffer that is drained this cycle still shows ready low.
REQ-017 SHALL capture s_axis_data[i] and set full[i] on a cycle where valid[i] & ready[i].
REQ-018 SHALL implement FSM states IDLE, ARB, HOLD.
REQ-019 IDLE: m_axis_valid=0; go to ARB when en=1.
REQ-020 ARB: when any channel has full[i] & chan_mask[i], select one round-robin, load m_axis_data/grant_id, clear full[i], set m_axis_valid, and go to HOLD; otherwise stay in ARB.
REQ-021 HOLD: keep m_axis_valid, m_axis_data and grant_id stable until dac_ready=1; on that cycle clear m_axis_valid and go to ARB.
REQ-022 Round-robin SHALL search from last_grant+1 upward, modulo N_CH; last_grant SHALL update only on a load in ARB.
REQ-023 Latency: a sample captured at cycle t with the FSM in ARB and no competitor SHALL appear on m_axis_valid at t+2.
REQ-024 If dac_ready=1 while m_axis_valid=0 and en=1, underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-025 If dac_ready and a new input capture occur in the same cycle, both SHALL take effect independently.
REQ-026 Clearing chan_mask[i] SHALL make channel i ineligible and deassert its ready; its buffered sample SHALL be retained, and SHALL become eligible again when the bit is set.
REQ-027 Changing chan_mask during HOLD SHALL NOT alter the presented sample.
REQ-028 When en=0, the next state SHALL be IDLE; all full flags and m_axis_valid SHALL clear; underrun_cnt and last_grant SHALL hold.
REQ-029 If dac_ready is asserted in IDLE, it SHALL be ignored and SHALL NOT count as an underrun.

Reset
REQ-030 On rst=1: state=IDLE, full=0, m_axis_valid=0, m_axis_data=0, grant_id=0, last_grant=N_CH-1, underrun_cnt=0.
REQ-031 While rst=1, s_axis_ready SHALL be 0.
REQ-032 Reset mid-HOLD SHALL discard the presented sample and all buffered samples with no residual handshake.

Structure
REQ-033 Package dac_pkg SHALL hold the arb_state_e enum (IDLE, ARB, HOLD) and the DAC_DATA_W=16 constant.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (req, last_grant -> grant_valid, grant_idx), purely combinational.
REQ-035 Integration SHALL connect m_axis_valid/m_axis_data to the DAC driver's s_axis_valid/s_axis_data, and its m_axis_ready to dac_ready.

Verification
REQ-036 Single channel: en=1, mask=4'b0001, ch0 sends 16'h1234 at cycle 10 -> m_axis_valid=1 at 12 with data 16'h1234 and grant_id=0; held until the dac_ready pulse.
REQ-037 Fairness: all 4 channels full with 16'hA000+i, dac_ready every 100 cycles -> grant order 0,1,2,3,0,... and no channel granted twice in a row while others are full.
REQ-038 Underrun: no input, 3 dac_ready pulses -> underrun_cnt=3; force the count to 16'hFFFF, apply another pulse -> stays 16'hFFFF.
REQ-039 Mask: ch2 full, chan_mask[2] cleared -> ch2 never granted and s_axis_ready[2]=0; set the bit again -> ch2 granted next.
REQ-040 Disable mid-HOLD: en dropped during HOLD -> next cycle m_axis_valid=0, full=0, state IDLE; underrun_cnt unchanged.
REQ-041 Reset mid-HOLD: rst pulsed for 1 cycle -> all outputs at reset values, then channel 0 is served first.
